// File: rtl/decoder_scan_ctrl.sv
// Channel scan sequencer driving decoder_3x8 select/enable.
// Walks the masked channels with a programmable dwell per channel.
module decoder_scan_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [7:0]       mask,
  input  logic [DIV_W-1:0] div,
  output logic [2:0]       s,
  output logic             enable,
  output logic             busy,
  output logic             sweep_done,
  output logic             wrap
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [1:0]       mode_r;
  logic [DIV_W-1:0] cnt;
  logic             dir_up;

  logic [3:0] up_c;
  logic [3:0] dn_c;
  logic [2:0] lo;
  logic [2:0] hi;

  // {found, index}: nearest set bit strictly above cur
  function automatic logic [3:0] find_up(
    input logic [7:0] m,
    input logic [2:0] cur
  );
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--)
      if (m[i] && i > int'(cur)) r = {1'b1, 3'(i)};
    return r;
  endfunction

  function automatic logic [3:0] find_dn(
    input logic [7:0] m,
    input logic [2:0] cur
  );
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (m[i] && i < int'(cur)) r = {1'b1, 3'(i)};
    return r;
  endfunction

  function automatic logic [2:0] lowest(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [2:0] highest(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  always_comb begin
    up_c = find_up(mask, s);
    dn_c = find_dn(mask, s);
    lo   = lowest(mask);
    hi   = highest(mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mode_r     <= 2'b00;
      cnt        <= '0;
      dir_up     <= 1'b1;
      s          <= 3'd0;
      enable     <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      wrap       <= 1'b0;
      sweep_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !stop && |mask) begin
            state  <= SCAN;
            mode_r <= mode;
            s      <= (mode == 2'b01) ? hi : lo;
            cnt    <= div;
            dir_up <= 1'b1;
            enable <= 1'b1;
            busy   <= 1'b1;
          end
        end
        SCAN: begin
          if (stop || (cnt == '0 && mask == '0)) begin
            state  <= IDLE;
            enable <= 1'b0;
            busy   <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - DIV_W'(1);
          end else begin
            cnt <= div;
            unique case (mode_r)
              2'b00: begin
                if (up_c[3]) s <= up_c[2:0];
                else begin
                  s    <= lo;
                  wrap <= 1'b1;
                end
              end
              2'b01: begin
                if (dn_c[3]) s <= dn_c[2:0];
                else begin
                  s    <= hi;
                  wrap <= 1'b1;
                end
              end
              2'b10: begin
                if (up_c[3]) s <= up_c[2:0];
                else begin
                  state      <= IDLE;
                  enable     <= 1'b0;
                  busy       <= 1'b0;
                  sweep_done <= 1'b1;
                end
              end
              default: begin
                // reversal skips the end channel; lone bit just stays
                if (dir_up && up_c[3]) s <= up_c[2:0];
                else if (!dir_up && dn_c[3]) s <= dn_c[2:0];
                else begin
                  wrap   <= 1'b1;
                  dir_up <= ~dir_up;
                  if (dir_up && dn_c[3]) s <= dn_c[2:0];
                  else if (!dir_up && up_c[3]) s <= up_c[2:0];
                end
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
